// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. One BITS_PER_CYCLE-wide ripple slice plus a
//   single carry flop processes the operands LSB chunk first, one chunk per
//   clock. It takes STEPS = WIDTH/BITS_PER_CYCLE RUN cycles, then one DONE cycle.
//
// Handshake (valid/ready style):
//   An operation is accepted on a rising edge where start=1 and ready=1.
//   a, b, cin and sub are captured on that edge and may change afterwards.
//   start is ignored while the unit is busy (RUN or DONE), and nothing is queued.
//   done pulses for exactly one cycle when sum/cout/overflow take their new
//   values. The outputs hold until the next done or reset.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   request an operation (sampled only while ready=1)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in (add mode only)
//   sub        in   0: a+b+cin, 1: a-b
//   ready      out  unit idle
//   done       out  one-cycle result strobe
//   sum        out  WIDTH-bit result
//   cout       out  carry out of MSB (sub mode: 1 = no borrow)
//   overflow   out  signed overflow
//   dbg_state  out  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // Ripple slice over the low chunk of A/B. c_into_top is the carry entering
  // the slice's top bit; on the final chunk that is the carry into the MSB.
  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic                      slice_cout;
  logic                      c_into_top;

  always_comb begin : p_slice
    logic c;
    c          = carry_q;
    slice_sum  = '0;
    c_into_top = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      c_into_top   = c;
      slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    slice_cout = c;
  end

  // Result register fills from the top, so after STEPS shifts the first
  // (least significant) chunk has arrived at bit 0.
  logic [WIDTH-1:0] res_shift;
  assign res_shift = (res_q >> BITS_PER_CYCLE)
                   | (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYCLE));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> BITS_PER_CYCLE;
        b_d     = b_q >> BITS_PER_CYCLE;
        res_d   = res_shift;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = S_DONE;
          sum_d   = res_shift;
          cout_d  = slice_cout;
          ovf_d   = c_into_top ^ slice_cout;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule
